// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode 7-seg scanner with a one-deep valid/ready input slot and frame-boundary commit.
// Optional leading dead time per digit period is enabled by defining SEG7_DEADTIME_EN.
module seg7_scan_mux #(
  parameter int DIGIT_TICKS = 100000,
  parameter int DEADTIME    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] LP_DEAD = CW'(DEADTIME);
`ifdef SEG7_DEADTIME_EN
  localparam logic LP_DEAD_EN = 1'b1;
`else
  localparam logic LP_DEAD_EN = 1'b0;
`endif

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_pending;
  logic          r_pend_full;

  logic          w_tick;
  logic          w_frame;
  logic          w_accept;
  logic          w_commit;
  logic [3:0]    w_digit;
  logic          w_upper_zero;
  logic          w_blank;
  logic          w_dead;

  // Handshake: a value transfers on any rising edge where value_valid and
  // value_ready are both high; value_ready is low exactly while the slot holds
  // a value that has not yet been committed to the display.
  assign value_ready = ~r_pend_full;
  assign w_accept    = value_valid & ~r_pend_full;

  assign w_tick   = (r_cnt == LP_LAST);
  assign w_frame  = w_tick & (r_idx == 2'd3);
  assign w_commit = w_frame & r_pend_full;
  assign w_dead   = LP_DEAD_EN & (r_cnt < LP_DEAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Commit and accept are exclusive: accept needs an empty slot, commit a full one,
  // so a value offered on the boundary cycle waits a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= 16'h0000;
      r_pending   <= 16'h0000;
      r_pend_full <= 1'b0;
    end else if (w_commit) begin
      r_shadow    <= r_pending;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pending   <= value;
      r_pend_full <= 1'b1;
    end
  end

  always_comb begin
    w_digit      = r_shadow[3:0];
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd1: begin
        w_digit      = r_shadow[7:4];
        w_upper_zero = (r_shadow[15:4] == 12'h000);
      end
      2'd2: begin
        w_digit      = r_shadow[11:8];
        w_upper_zero = (r_shadow[15:8] == 8'h00);
      end
      2'd3: begin
        w_digit      = r_shadow[15:12];
        w_upper_zero = (r_shadow[15:12] == 4'h0);
      end
      default: begin
        w_digit      = r_shadow[3:0];
        w_upper_zero = 1'b0;
      end
    endcase
  end

  assign w_blank = blank_lz & w_upper_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      nibble     <= 4'h0;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame;
      nibble     <= w_blank ? 4'h0 : w_digit;
      an         <= (w_blank | w_dead) ? 4'b1111 : ~(4'b0001 << r_idx);
      dp         <= w_dead ? 1'b1 : ~dp_mask[r_idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a time-based behavioural model.
module tb_seg7_scan_mux;

  localparam int DT   = 32;
  localparam int DEAD = 4;
`ifdef SEG7_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int edge_n = 0;
  int fd_seen = 0;

  seg7_scan_mux #(.DIGIT_TICKS(DT), .DEADTIME(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .nibble(nibble), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: the display position is pure arithmetic on cycles since reset release.
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] pend_q[$];
  logic [3:0]  exp_an, exp_nib;
  logic        exp_dp, exp_fd, exp_ready;

  always @(posedge clk or negedge rst_n) begin
    int cnt, idx;
    bit frame, blank, dead;
    logic [15:0] upper;
    if (!rst_n) begin
      m_t = 0; m_shadow = 16'h0; pend_q.delete();
      exp_an = 4'b1111; exp_nib = 4'h0; exp_dp = 1'b1; exp_fd = 1'b0; exp_ready = 1'b1;
    end else begin
      cnt   = m_t % DT;
      idx   = (m_t / DT) % 4;
      frame = ((m_t % (4 * DT)) == (4 * DT - 1));
      upper = m_shadow >> (4 * idx);
      blank = blank_lz && (idx > 0) && (upper == 16'h0);
      dead  = DEAD_EN && (cnt < DEAD);
      exp_nib = blank ? 4'h0 : upper[3:0];
      exp_an  = (blank || dead) ? 4'b1111 : ~(4'b0001 << idx);
      exp_dp  = dead ? 1'b1 : ~dp_mask[idx];
      exp_fd  = frame;
      if (frame && pend_q.size() != 0) m_shadow = pend_q.pop_front();
      else if (value_valid && pend_q.size() == 0) pend_q.push_back(value);
      exp_ready = (pend_q.size() == 0);
      m_t++;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t (edge %0d)", nm, got, exp, $time, edge_n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", {12'h0, an}, {12'h0, exp_an});
      chk("nibble", {12'h0, nibble}, {12'h0, exp_nib});
      chk("dp", {15'h0, dp}, {15'h0, exp_dp});
      chk("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
      chk("value_ready", {15'h0, value_ready}, {15'h0, exp_ready});
    end
  end

  task automatic goto(input int target);
    while (edge_n < target) begin
      @(negedge clk);
      edge_n++;
      if (frame_done) fd_seen++;
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] e_an, input logic [3:0] e_nib);
    chk({nm, "_an"}, {12'h0, an}, {12'h0, e_an});
    chk({nm, "_nib"}, {12'h0, nibble}, {12'h0, e_nib});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 4'b1111, 4'h0);
    chk("reset_dp", {15'h0, dp}, 16'h1);
    chk("reset_ready", {15'h0, value_ready}, 16'h1);
    chk("reset_fd", {15'h0, frame_done}, 16'h0);

    // Scan: BEEF offered once, first frame still shows 0000
    rst_n = 1'b1; edge_n = 0;
    value = 16'hBEEF; value_valid = 1'b1;
    goto(1);
    chk("first_nib", {12'h0, nibble}, 16'h0);
    chk("beef_acc_ready", {15'h0, value_ready}, 16'h0);
    value_valid = 1'b0;
    goto(6);    lit("f0_d0", 4'b1110, 4'h0);
    goto(128);  lit("f0_d3", 4'b0111, 4'h0);
    chk("fd_pulse", {15'h0, frame_done}, 16'h1);
    goto(134);  lit("beef_d0", 4'b1110, 4'hF);
    chk("beef_ready", {15'h0, value_ready}, 16'h1);
    goto(166);  lit("beef_d1", 4'b1101, 4'hE);
    goto(198);  lit("beef_d2", 4'b1011, 4'hE);
    goto(230);  lit("beef_d3", 4'b0111, 4'hB);

    // Handshake: 1234 taken, 5678 refused until the boundary
    value = 16'h1234; value_valid = 1'b1;
    goto(231);  chk("hs_full", {15'h0, value_ready}, 16'h0);
    value = 16'h5678;
    goto(240);  chk("hs_refuse", {15'h0, value_ready}, 16'h0);
    goto(256);  chk("hs_commit_ready", {15'h0, value_ready}, 16'h1);
    goto(257);  chk("hs_5678_acc", {15'h0, value_ready}, 16'h0);
    value_valid = 1'b0;
    goto(262);  lit("hs_d0", 4'b1110, 4'h4);
    goto(294);  lit("hs_d1", 4'b1101, 4'h3);

    // Blanking with 0042, then 0000
    value = 16'h0042; value_valid = 1'b1; dp_mask = 4'b0101; blank_lz = 1'b1;
    goto(385);  chk("bl_acc", {15'h0, value_ready}, 16'h0);
    value_valid = 1'b0;
    goto(518);  lit("bl_d0", 4'b1110, 4'h2);
    chk("bl_dp0", {15'h0, dp}, 16'h0);
    goto(550);  lit("bl_d1", 4'b1101, 4'h4);
    chk("bl_dp1", {15'h0, dp}, 16'h1);
    goto(582);  lit("bl_d2", 4'b1111, 4'h0);
    chk("bl_dp2", {15'h0, dp}, 16'h0);
    goto(614);  lit("bl_d3", 4'b1111, 4'h0);
    value = 16'h0000; value_valid = 1'b1;
    goto(615);  value_valid = 1'b0;
    goto(646);  lit("z_d0", 4'b1110, 4'h0);
    goto(678);  lit("z_d1", 4'b1111, 4'h0);

    // Boundary: offer on the frame_done cycle with the slot empty
    goto(767);
    chk("bd_ready", {15'h0, value_ready}, 16'h1);
    value = 16'hABCD; value_valid = 1'b1;
    goto(768);
    chk("bd_acc", {15'h0, value_ready}, 16'h0);
    chk("bd_fd", {15'h0, frame_done}, 16'h1);
    value_valid = 1'b0; fd_seen = 0;
    goto(774);  lit("bd_late", 4'b1110, 4'h0);
    goto(902);  lit("bd_show", 4'b1110, 4'hD);
    goto(1152);
    chk("fd_count", 16'(fd_seen), 16'd3);

    // Reset while digit 2 is lit and the slot is full
    value = 16'h9999; value_valid = 1'b1;
    goto(1153); value_valid = 1'b0;
    goto(1225);
    chk("rst_pre_ready", {15'h0, value_ready}, 16'h0);
    lit("rst_pre", 4'b1011, 4'hB);
    #2 rst_n = 1'b0;
    #1;
    lit("rst_async", 4'b1111, 4'h0);
    chk("rst_async_ready", {15'h0, value_ready}, 16'h1);
    blank_lz = 1'b0; dp_mask = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; edge_n = 0;
    goto(6);    lit("rel_d0", 4'b1110, 4'h0);
    chk("rel_ready", {15'h0, value_ready}, 16'h1);
    goto(134);  lit("rel_f1_d0", 4'b1110, 4'h0);
    goto(166);  lit("rel_f1_d1", 4'b1101, 4'h0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      value       = 16'($urandom) >> (4 * $urandom_range(0, 4));
      value_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
    end
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
